// File: rtl/crossbar_scheduler_pkg.sv
// Shared types and constants for the 4x4 crossbar scheduler.
package crossbar_scheduler_pkg;

   localparam int NUM_PORTS = 4;

   typedef logic [1:0] port_idx_t;

   // Optional packed form of one input-buffer head request.
   typedef struct packed {
      logic      valid;
      port_idx_t port;
   } port_req_t;

   // Number of set bits in a 4-bit mask.
   function automatic logic [2:0] popcount4(input logic [3:0] m);
      return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
   endfunction

endpackage

// File: rtl/crossbar_scheduler_if.sv
// Request/grant bundle between the input buffers, output buffers and the scheduler.
interface crossbar_scheduler_if #(
   parameter int CNT_W = 16
);
   import crossbar_scheduler_pkg::*;

   // Handshake: req_valid[i] says input i holds a packet bound for req_port[i];
   // ob_ready[j] says output j can take one packet this cycle. A transfer i->j
   // happens in exactly the cycle where in_grant[i], out_valid[j] and
   // out_sel[j]==i are all high; nothing is held across cycles.
   logic [NUM_PORTS-1:0]            req_valid;
   port_idx_t [NUM_PORTS-1:0]       req_port;
   logic [NUM_PORTS-1:0]            ob_ready;
   logic                            arb_en;
   logic [NUM_PORTS-1:0]            in_grant;
   logic [NUM_PORTS-1:0]            out_valid;
   port_idx_t [NUM_PORTS-1:0]       out_sel;
   logic [CNT_W-1:0]                contention_cnt;

   modport master (
      output req_valid, req_port, ob_ready, arb_en,
      input  in_grant, out_valid, out_sel, contention_cnt
   );

   modport slave (
      input  req_valid, req_port, ob_ready, arb_en,
      output in_grant, out_valid, out_sel, contention_cnt
   );

endinterface

// File: rtl/crossbar_scheduler_rr_pick4.sv
// Combinational 4-way round-robin picker with an urgent-first override.
module crossbar_scheduler_rr_pick4
   import crossbar_scheduler_pkg::*;
(
   input  logic [3:0] eligible,
   input  logic [3:0] urgent,
   input  port_idx_t  ptr,
   output logic       found,
   output port_idx_t  idx
);

   logic [3:0] pool;
   port_idx_t  cand;

   // Restrict to urgent requesters when any exist, then take the first set bit from ptr upward.
   always_comb begin
      pool  = ((eligible & urgent) != 4'b0000) ? (eligible & urgent) : eligible;
      found = |pool;
      idx   = '0;
      cand  = '0;
      // Scanning from the far end lets the closest hit to ptr overwrite the others.
      for (int k = 3; k >= 0; k--) begin
         cand = ptr + port_idx_t'(k);
         if (pool[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/crossbar_scheduler.sv
// Per-output round-robin crossbar scheduler with starvation override and contention stats.
module crossbar_scheduler
   import crossbar_scheduler_pkg::*;
#(
   parameter int MAX_WAIT = 7,
   parameter int CNT_W    = 16
)(
   input  logic                 clock,
   input  logic                 reset_n,
   crossbar_scheduler_if.slave  bus
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   port_idx_t                ptr      [NUM_PORTS];
   logic [WAIT_W-1:0]        wait_cnt [NUM_PORTS];
   logic [CNT_W-1:0]         cnt_q;

   logic [NUM_PORTS-1:0]     urgent;
   logic [NUM_PORTS-1:0]     elig     [NUM_PORTS];  // elig[j][i]: input i may go to output j
   logic [NUM_PORTS-1:0]     found;
   port_idx_t                pick     [NUM_PORTS];
   port_idx_t [NUM_PORTS-1:0] sel;
   logic [NUM_PORTS-1:0]     grant_vec;
   logic                     contention;

   // Eligibility and urgency; reset_n gates everything so grants drop while reset is held.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         urgent[i] = (wait_cnt[i] >= WAIT_W'(MAX_WAIT));
      end
      for (int j = 0; j < NUM_PORTS; j++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            elig[j][i] = reset_n && bus.arb_en && bus.ob_ready[j] &&
                         bus.req_valid[i] && (bus.req_port[i] == port_idx_t'(j));
         end
      end
   end

   for (genvar j = 0; j < NUM_PORTS; j++) begin : g_pick
      crossbar_scheduler_rr_pick4 u_rr_pick4 (
         .eligible (elig[j]),
         .urgent   (urgent),
         .ptr      (ptr[j]),
         .found    (found[j]),
         .idx      (pick[j])
      );
   end

   // Fold per-output winners into input grants, output selects and the contention flag.
   always_comb begin
      grant_vec  = '0;
      sel        = '0;
      contention = 1'b0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (found[j]) begin
            sel[j]               = pick[j];
            grant_vec[pick[j]]   = 1'b1;
         end
         if (popcount4(elig[j]) >= 3'd2) contention = 1'b1;
      end
   end

   assign bus.in_grant       = grant_vec;
   assign bus.out_valid      = found;
   assign bus.out_sel        = sel;
   assign bus.contention_cnt = cnt_q;

   // Rotate each output's pointer to just past the input it served; hold otherwise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < NUM_PORTS; j++) ptr[j] <= '0;
      end else begin
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (found[j]) ptr[j] <= pick[j] + 2'd1;
         end
      end
   end

   // Count consecutive denied cycles per requesting input, saturating at MAX_WAIT.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.req_valid[i] && !grant_vec[i]) begin
               if (wait_cnt[i] < WAIT_W'(MAX_WAIT)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end else begin
               wait_cnt[i] <= '0;
            end
         end
      end
   end

   // Saturating count of cycles with at least one contended output.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (contention && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Directed bench for crossbar_scheduler with a rule-level reference model.
module tb_crossbar_scheduler;
   import crossbar_scheduler_pkg::*;

   localparam int MAX_WAIT = 7;
   localparam int CNT_W    = 16;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   tests   = 0;
   int   fails   = 0;

   // Reference model state
   int mptr  [4];
   int mwait [4];
   int mcnt;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   crossbar_scheduler_if #(.CNT_W(CNT_W)) bus ();

   crossbar_scheduler #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input logic [3:0] v, input logic [7:0] ports,
                          input logic [3:0] ob, input logic en);
      bus.req_valid = v;
      bus.req_port  = ports;
      bus.ob_ready  = ob;
      bus.arb_en    = en;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_clear();
      for (int k = 0; k < 4; k++) begin
         mptr[k]  = 0;
         mwait[k] = 0;
      end
      mcnt = 0;
   endtask

   function automatic bit is_elig(input int i, input int j);
      return reset_n && bus.arb_en && bus.ob_ready[j] && bus.req_valid[i] &&
             (int'(bus.req_port[i]) == j);
   endfunction

   // For every output: walk inputs in pointer order, prefer the first urgent one, else the first.
   task automatic model_eval(output logic [3:0] g, output logic [3:0] v,
                             output logic [7:0] s, output bit cont);
      g = '0; v = '0; s = '0; cont = 0;
      for (int j = 0; j < 4; j++) begin
         int n = 0;
         int first_any = -1;
         int first_urg = -1;
         int winner;
         for (int k = 0; k < 4; k++) begin
            int i = (mptr[j] + k) % 4;
            if (is_elig(i, j)) begin
               n++;
               if (first_any < 0) first_any = i;
               if (first_urg < 0 && mwait[i] >= MAX_WAIT) first_urg = i;
            end
         end
         winner = (first_urg >= 0) ? first_urg : first_any;
         if (n >= 2) cont = 1;
         if (winner >= 0) begin
            v[j]        = 1'b1;
            g[winner]   = 1'b1;
            s[2*j +: 2] = 2'(winner);
         end
      end
   endtask

   // ---------------- scoreboard / compare ----------------
   initial begin : compare_proc
      logic [3:0] eg, ev;
      logic [7:0] es;
      bit         ec;
      int         nptr [4];
      int         nwait [4];
      int         ncnt;
      model_clear();
      forever begin
         @(negedge clock);
         if (!reset_n) model_clear();
         model_eval(eg, ev, es, ec);
         check("cyc_in_grant",  32'(bus.in_grant),       32'(eg));
         check("cyc_out_valid", 32'(bus.out_valid),      32'(ev));
         check("cyc_out_sel",   32'(bus.out_sel),        32'(es));
         check("cyc_cont_cnt",  32'(bus.contention_cnt), 32'(mcnt));
         for (int j = 0; j < 4; j++)
            nptr[j] = ev[j] ? ((int'(es[2*j +: 2]) + 1) % 4) : mptr[j];
         for (int i = 0; i < 4; i++)
            nwait[i] = (bus.req_valid[i] && !eg[i]) ?
                       ((mwait[i] < MAX_WAIT) ? mwait[i] + 1 : MAX_WAIT) : 0;
         ncnt = (ec && mcnt < CNT_MAX) ? mcnt + 1 : mcnt;
         @(posedge clock);
         if (!reset_n) begin
            model_clear();
         end else begin
            for (int k = 0; k < 4; k++) begin
               mptr[k]  = nptr[k];
               mwait[k] = nwait[k];
            end
            mcnt = ncnt;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      fails++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // ---------------- directed stimulus ----------------
   initial begin
      set_req(4'h0, 8'h00, 4'h0, 1'b0);
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_in_grant", 32'(bus.in_grant), 32'h0);
      check("rst_cont_cnt", 32'(bus.contention_cnt), 32'h0);
      reset_n = 1'b1;

      // Single requester: input 0 -> output 2
      set_req(4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, 4'hF, 1'b1);
      #1;
      check("single_in_grant",  32'(bus.in_grant),  32'b0001);
      check("single_out_valid", 32'(bus.out_valid), 32'b0100);
      check("single_out_sel",   32'(bus.out_sel),   32'h00);
      tick();
      check("single_model_ptr2", 32'(mptr[2]), 32'd1);
      set_req(4'h0, 8'h00, 4'hF, 1'b1);
      tick();

      // All four inputs contend for output 1: strict rotation 0,1,2,3,0,1,2,3
      set_req(4'hF, {2'd1, 2'd1, 2'd1, 2'd1}, 4'hF, 1'b1);
      for (int k = 0; k < 8; k++) begin
         #1;
         check("rot_in_grant",  32'(bus.in_grant),  32'(4'b0001 << (k % 4)));
         check("rot_out_valid", 32'(bus.out_valid), 32'b0010);
         check("rot_out_sel",   32'(bus.out_sel),   32'((k % 4) << 2));
         tick();
      end
      check("rot_cont_cnt", 32'(bus.contention_cnt), 32'd8);
      set_req(4'h0, 8'h00, 4'hF, 1'b1);
      tick();

      // Identity mapping: full parallel grant, no contention
      set_req(4'hF, {2'd3, 2'd2, 2'd1, 2'd0}, 4'hF, 1'b1);
      #1;
      check("ident_in_grant",  32'(bus.in_grant),  32'hF);
      check("ident_out_valid", 32'(bus.out_valid), 32'hF);
      check("ident_out_sel",   32'(bus.out_sel),   32'he4);
      tick();
      check("ident_cont_cnt", 32'(bus.contention_cnt), 32'd8);
      check("ident_model_ptr1", 32'(mptr[1]), 32'd2);
      set_req(4'h0, 8'h00, 4'hF, 1'b1);
      tick();

      // Inputs 0 and 2 blocked on output 3, then released
      set_req(4'b0101, {2'd0, 2'd3, 2'd0, 2'd3}, 4'b0111, 1'b1);
      for (int k = 0; k < 7; k++) begin
         #1;
         check("block_in_grant",  32'(bus.in_grant),  32'h0);
         check("block_out_valid", 32'(bus.out_valid), 32'h0);
         tick();
      end
      check("block_model_wait0", 32'(mwait[0]), 32'd7);
      check("block_model_wait2", 32'(mwait[2]), 32'd7);
      check("block_cont_cnt", 32'(bus.contention_cnt), 32'd8);
      bus.ob_ready = 4'hF;
      #1;
      check("unblock1_in_grant",  32'(bus.in_grant),  32'b0001);
      check("unblock1_out_valid", 32'(bus.out_valid), 32'b1000);
      check("unblock1_out_sel",   32'(bus.out_sel),   32'h00);
      tick();
      check("unblock1_cont_cnt", 32'(bus.contention_cnt), 32'd9);
      #1;
      check("unblock2_in_grant", 32'(bus.in_grant), 32'b0100);
      check("unblock2_out_sel",  32'(bus.out_sel),  32'h80);
      tick();
      check("unblock2_cont_cnt", 32'(bus.contention_cnt), 32'd10);
      set_req(4'h0, 8'h00, 4'hF, 1'b1);
      tick();

      // Starvation override: input 0 denied via arb_en=0, then beats input 3 despite ptr[1]=2
      set_req(4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, 4'hF, 1'b0);
      for (int k = 0; k < 7; k++) begin
         #1;
         check("dis_in_grant", 32'(bus.in_grant), 32'h0);
         tick();
      end
      check("dis_model_wait0", 32'(mwait[0]), 32'd7);
      check("dis_cont_cnt", 32'(bus.contention_cnt), 32'd10);
      set_req(4'b1001, {2'd1, 2'd0, 2'd0, 2'd1}, 4'hF, 1'b1);
      #1;
      check("urgent_in_grant",  32'(bus.in_grant),  32'b0001);
      check("urgent_out_valid", 32'(bus.out_valid), 32'b0010);
      check("urgent_out_sel",   32'(bus.out_sel),   32'h00);
      tick();
      check("urgent_cont_cnt", 32'(bus.contention_cnt), 32'd11);
      set_req(4'h0, 8'h00, 4'hF, 1'b1);
      tick();

      // Reset mid-stream with active grants
      set_req(4'hF, {2'd3, 2'd2, 2'd1, 2'd0}, 4'hF, 1'b1);
      #1;
      check("pre_rst_in_grant", 32'(bus.in_grant), 32'hF);
      reset_n = 1'b0;
      #1;
      check("mid_rst_in_grant",  32'(bus.in_grant),       32'h0);
      check("mid_rst_out_valid", 32'(bus.out_valid),      32'h0);
      check("mid_rst_cont_cnt",  32'(bus.contention_cnt), 32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      set_req(4'h0, 8'h00, 4'hF, 1'b1);
      tick();
      // ptr[1] was 1 before reset; a cleared pointer must serve input 0 first
      set_req(4'hF, {2'd1, 2'd1, 2'd1, 2'd1}, 4'hF, 1'b1);
      #1;
      check("post_rst_in_grant", 32'(bus.in_grant), 32'b0001);
      tick();
      check("post_rst_cont_cnt", 32'(bus.contention_cnt), 32'd1);
      set_req(4'h0, 8'h00, 4'hF, 1'b1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/crossbar_scheduler.md
Name: crossbar_scheduler

Overview:
- Per-output round-robin scheduler for the router's 4x4 crossbar.
- Each cycle it takes the four input-buffer requests, each already decoded to a 2-bit output-port select, and grants at most one input per output port.
- Each input is granted at most once. The datapath uses the resulting selects for muxing and for input-buffer reads.
- Rotating priority pointers and per-input starvation counters guarantee bounded wait. A saturating contention counter supports performance debug.

Parameters:
- NUM_PORTS, 4, number of input and output ports (fixed at 4 in this revision).
- MAX_WAIT, 7, number of consecutive denied cycles after which a requesting input becomes urgent.
- CNT_W, 16, width of the contention event counter.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  4  input i has a packet at the head of its buffer.
- req_port  in  4x2  output port requested by input i (from the routing table).
- ob_ready  in  4  output buffer j can accept a packet this cycle.
- arb_en  in  1  global enable; 0 forces all grants low.
- in_grant  out  4  input i is granted this cycle; drives read_from_ib.
- out_valid  out  4  output j receives a packet this cycle.
- out_sel  out  4x2  input index muxed onto output j; 0 when out_valid[j]=0.
- contention_cnt  out  CNT_W  saturating count of cycles with at least one output that has more than one eligible requester.

Behaviour:
- Grants are combinational, with zero-cycle latency from req_valid/req_port/ob_ready. Pointers, wait counters and contention_cnt are registered.
- Reset values: ptr[j]=0 for all j, wait_cnt[i]=0, contention_cnt=0. Outputs follow from those state values and the current inputs; no stale grants.
- Eligibility: input i is eligible for output j iff req_valid[i] && req_port[i]==j && ob_ready[j] && arb_en.
- urgent[i] = (wait_cnt[i] >= MAX_WAIT).
- Per-output selection: scan inputs in order ptr[j], ptr[j]+1, ... (mod 4).
  - The first eligible urgent input wins.
  - If there is no eligible urgent input, the first eligible input wins.
- Each input names exactly one output, so the grants are conflict-free. The winner sets in_grant[i]=1, out_valid[j]=1 and out_sel[j]=i.
- Pointer update at posedge: if out_valid[j], then ptr[j] <= out_sel[j]+1 (mod 4, 2-bit wrap). Otherwise ptr[j] holds.
- Wait counter update at posedge, per input:
  - req_valid[i] && !in_grant[i]: wait_cnt[i] increments, saturating at MAX_WAIT.
  - Otherwise wait_cnt[i] clears to 0.
  - Denial caused by ob_ready=0 or arb_en=0 still counts.
- contention_cnt increments when any output j has two or more eligible inputs that cycle. It saturates at all-ones and never wraps.
- ob_ready[j]=0: no grant for output j, ptr[j] holds, and requesters of j accumulate wait.
- arb_en=0: all outputs are 0, pointers hold, contention is not counted, and wait counters keep running for requesting inputs.
- Single requester: granted immediately, regardless of pointer position.
- All four inputs requesting the same output: grants are issued in strict rotation from ptr, with one grant per cycle. Worst-case wait is 3 cycles while ob_ready stays high.
- Reset asserted mid-operation: all state clears asynchronously and grants drop in the same cycle.
- The design has no multi-cycle lock. Packets are single-flit, so each grant is independent per cycle.

Decomposition:
- RouterPkg gains:
  - port_idx_t (logic [1:0]);
  - NUM_PORTS constant;
  - a port_req_t struct {valid, port}, optional, for packing req_valid/req_port.
- One sub-module, rr_pick4. Inputs: a 4-bit eligible mask, a 4-bit urgent mask and a 2-bit ptr. Outputs: found and a 2-bit idx. It is purely combinational and instantiated once per output.
- Pointer, wait-counter and stats registers stay in crossbar_scheduler.
- A Routing_Logic revision replaces its internal arbiter with this block.

Test Plan:
- Reset, then req_valid=4'b0001, req_port[0]=2, ob_ready=4'hF -> in_grant=0001, out_valid=0100, out_sel[2]=0 in the same cycle; ptr[2]=1 after the clock edge.
- All inputs request port 1 for 8 cycles with ob_ready=F -> grant order 0,1,2,3,0,1,2,3; contention_cnt=8.
- Inputs 0->0, 1->1, 2->2, 3->3 simultaneously -> in_grant=1111, out_valid=1111, out_sel = {3,2,1,0}; contention_cnt unchanged.
- Inputs 0 and 2 request port 3 with ob_ready[3]=0 for 7 cycles, then ob_ready[3]=1 -> no grants while blocked; wait_cnt[0]=wait_cnt[2]=7 (urgent); input 0 wins first (ptr=0), input 2 the next cycle.
- Starvation override: set ptr[1]=2 by granting input 1 on port 1. Hold input 0 denied 7 cycles via arb_en=0, then input 0 and input 3 both request port 1 with arb_en=1 -> input 0 (urgent) wins over input 3 despite ptr.
- Assert reset_n=0 mid-stream with active grants -> in_grant/out_valid drop immediately; ptr, wait_cnt and contention_cnt read 0 after release.
